// File: rtl/trig_mux_scan.sv
// trig_mux_scan: registered channel multiplexer with a direct-select mode and
// a masked scan mode. A scan emits every enabled channel in ascending order
// through a valid/ready output slot, skipping disabled channels at no cycle
// cost, then pulses done once the last sample has been taken downstream.
module trig_mux_scan #(
    parameter int WIDTH = 32,
    parameter int NCH   = 16,
    parameter int SELW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 start,
    input  logic [NCH-1:0]       en_mask,
    input  logic                 q_ready,
    output logic [WIDTH-1:0]     q,
    output logic [SELW-1:0]      q_ch,
    output logic                 q_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    // Channel table padded to the full select range so any SELW-wide index is legal.
    localparam int NSLOT = 2 ** SELW;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [SELW-1:0]  q_ch_reg, q_ch_next;
    logic             q_valid_reg, q_valid_next;
    logic             done_reg, done_next;
    logic [NCH-1:0]   mask_reg, mask_next;
    logic [SELW-1:0]  ptr_reg, ptr_next;

    logic [WIDTH-1:0] chan [NSLOT];
    logic [SELW-1:0]  first_idx;
    logic             first_any;
    logic [SELW-1:0]  next_idx;
    logic             next_any;
    logic             sel_ok;
    logic             slot_free;

    // Unpack the flat input bus; slots beyond NCH read as zero and are never selected.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_chan
            if (gi < NCH) begin : g_live
                assign chan[gi] = din[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    assign sel_ok    = (32'(sel) < NCH);
    assign slot_free = !q_valid_reg || q_ready;

    // Lowest enabled channel of the incoming mask (first scan target).
    always_comb begin
        first_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                first_idx = SELW'(i);
            end
        end
    end

    assign first_any = |en_mask;

    // Next enabled channel strictly above the pointer; none means the scan is finished.
    always_comb begin
        next_idx = '0;
        next_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_reg[i] && (SELW'(i) > ptr_reg)) begin
                next_idx = SELW'(i);
                next_any = 1'b1;
            end
        end
    end

    // Next-state and output-register logic.
    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        q_ch_next    = q_ch_reg;
        q_valid_next = q_valid_reg;
        done_next    = 1'b0;
        mask_next    = mask_reg;
        ptr_next     = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (!mode) begin
                    if (sel_ok) begin
                        q_next       = chan[sel];
                        q_ch_next    = sel;
                        q_valid_next = 1'b1;
                    end else begin
                        q_valid_next = 1'b0;
                    end
                end else begin
                    // Any sample left over is retired by the usual handshake.
                    if (q_ready) begin
                        q_valid_next = 1'b0;
                    end
                    if (start) begin
                        if (first_any) begin
                            mask_next  = en_mask;
                            ptr_next   = first_idx;
                            state_next = SCAN;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
            end
            SCAN: begin
                if (slot_free) begin
                    q_next       = chan[ptr_reg];
                    q_ch_next    = ptr_reg;
                    q_valid_next = 1'b1;
                    if (next_any) begin
                        ptr_next = next_idx;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (q_ready || !q_valid_reg) begin
                    q_valid_next = 1'b0;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            q_ch_reg    <= '0;
            q_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
            mask_reg    <= '0;
            ptr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            q_reg       <= q_next;
            q_ch_reg    <= q_ch_next;
            q_valid_reg <= q_valid_next;
            done_reg    <= done_next;
            mask_reg    <= mask_next;
            ptr_reg     <= ptr_next;
        end
    end

    assign q       = q_reg;
    assign q_ch    = q_ch_reg;
    assign q_valid = q_valid_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;

endmodule

// File: tb/tb_trig_mux_scan.sv
// Directed testbench for trig_mux_scan: direct mode, full and sparse scans,
// back-pressure, empty mask, reset mid-scan and ignored restarts.
module tb_trig_mux_scan;

    localparam int WIDTH = 32;
    localparam int NCH   = 16;
    localparam int SELW  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] din;
    logic [SELW-1:0]      sel;
    logic                 mode;
    logic                 start;
    logic [NCH-1:0]       en_mask;
    logic                 q_ready;
    logic [WIDTH-1:0]     q;
    logic [SELW-1:0]      q_ch;
    logic                 q_valid;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;

    int sp_ch  [8] = '{0, 0, 5, 5, 10, 10, 15, 15};
    int sp_rdy [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    trig_mux_scan #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .sel     (sel),
        .mode    (mode),
        .start   (start),
        .en_mask (en_mask),
        .q_ready (q_ready),
        .q       (q),
        .q_ch    (q_ch),
        .q_valid (q_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch_val(input int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
        din[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = '0; mode = 1'b1; start = 1'b0; en_mask = '0; q_ready = 1'b0;
        for (int k = 0; k < NCH; k++) set_ch(k, ch_val(k));
        tick; tick;
        rst = 1'b0;
        check_value("rst_q", q, 0);
        check_value("rst_qch", q_ch, 0);
        check_value("rst_valid", q_valid, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);

        // Direct mode
        mode = 1'b0; sel = 4'd5;
        tick;
        $display("direct sel=5 q=%h q_ch=%0d", q, q_ch);
        check_value("dir5_q", q, 32'hA5A5_0005);
        check_value("dir5_ch", q_ch, 5);
        check_value("dir5_valid", q_valid, 1);
        check_value("dir5_busy", busy, 0);
        sel = 4'd15;
        tick;
        $display("direct sel=15 q=%h q_ch=%0d", q, q_ch);
        check_value("dir15_q", q, 32'hA5A5_000F);
        check_value("dir15_ch", q_ch, 15);
        set_ch(15, 32'h1234_5678);
        tick;
        $display("direct live q=%h", q);
        check_value("dir15_live", q, 32'h1234_5678);
        set_ch(15, ch_val(15));

        // Full scan, q_ready held high
        mode = 1'b1; q_ready = 1'b1; en_mask = 16'hFFFF; start = 1'b1;
        tick;
        start = 1'b0;
        check_value("full_busy", busy, 1);
        check_value("full_start_valid", q_valid, 0);
        for (int k = 0; k < NCH; k++) begin
            tick;
            $display("full scan q_ch=%0d q=%h valid=%0d", q_ch, q, q_valid);
            check_value($sformatf("full_ch%0d", k), q_ch, k);
            check_value($sformatf("full_q%0d", k), q, ch_val(k));
            check_value($sformatf("full_v%0d", k), q_valid, 1);
            check_value($sformatf("full_d%0d", k), done, 0);
        end
        tick;
        $display("full scan end done=%0d busy=%0d", done, busy);
        check_value("full_done", done, 1);
        check_value("full_busy_end", busy, 0);
        check_value("full_valid_end", q_valid, 0);
        tick;
        check_value("full_done_pulse", done, 0);

        // Sparse scan with back-pressure and live data on channel 10
        set_ch(10, 32'hDEAD_000A);
        en_mask = 16'h8421; start = 1'b1; q_ready = 1'b1;
        tick;
        start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            q_ready = sp_rdy[s][0];
            tick;
            $display("sparse step %0d ready=%0d q_ch=%0d q=%h", s, sp_rdy[s], q_ch, q);
            check_value($sformatf("sp_ch%0d", s), q_ch, sp_ch[s]);
            check_value($sformatf("sp_q%0d", s), q,
                        (sp_ch[s] == 10) ? 32'hDEAD_000A : ch_val(sp_ch[s]));
            check_value($sformatf("sp_v%0d", s), q_valid, 1);
            check_value($sformatf("sp_d%0d", s), done, 0);
            check_value($sformatf("sp_b%0d", s), busy, 1);
        end
        q_ready = 1'b1;
        tick;
        $display("sparse end done=%0d busy=%0d", done, busy);
        check_value("sp_done", done, 1);
        check_value("sp_busy_end", busy, 0);
        tick;
        check_value("sp_done_pulse", done, 0);
        set_ch(10, ch_val(10));

        // Empty mask
        en_mask = '0; start = 1'b1;
        tick;
        start = 1'b0;
        $display("empty mask done=%0d busy=%0d valid=%0d", done, busy, q_valid);
        check_value("empty_done", done, 1);
        check_value("empty_busy", busy, 0);
        check_value("empty_valid", q_valid, 0);
        tick;
        check_value("empty_done_pulse", done, 0);
        check_value("empty_valid2", q_valid, 0);

        // Reset mid-scan after three captures; reset overrides start
        en_mask = 16'hFFFF; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        check_value("mid_ch", q_ch, 2);
        rst = 1'b1; start = 1'b1;
        tick;
        $display("mid-scan reset q=%h q_ch=%0d valid=%0d busy=%0d done=%0d", q, q_ch, q_valid, busy, done);
        check_value("mid_q", q, 0);
        check_value("mid_qch", q_ch, 0);
        check_value("mid_valid", q_valid, 0);
        check_value("mid_busy", busy, 0);
        check_value("mid_done", done, 0);
        rst = 1'b0; start = 1'b0;
        tick;
        check_value("mid_done2", done, 0);
        en_mask = 16'h000C; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check_value("re_ch2", q_ch, 2);
        tick;
        check_value("re_ch3", q_ch, 3);
        check_value("re_q3", q, ch_val(3));
        tick;
        $display("rescan end done=%0d", done);
        check_value("re_done", done, 1);

        // Start, mask, mode and sel changes during a scan are ignored
        en_mask = 16'h0012; start = 1'b1;
        tick;
        en_mask = 16'h0001; mode = 1'b0; sel = 4'd7;
        tick;
        $display("ignored start q_ch=%0d", q_ch);
        check_value("ign_ch1", q_ch, 1);
        check_value("ign_d1", done, 0);
        tick;
        check_value("ign_ch4", q_ch, 4);
        check_value("ign_q4", q, ch_val(4));
        check_value("ign_d4", done, 0);
        tick;
        $display("ignored start end done=%0d busy=%0d", done, busy);
        check_value("ign_done", done, 1);
        check_value("ign_busy", busy, 0);
        start = 1'b0; mode = 1'b1; q_ready = 1'b0;
        tick;
        check_value("ign_done_pulse", done, 0);
        check_value("ign_busy2", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trig_mux_scan.md
TRIG_MUX_SCAN -- requirements
Module: trig_mux_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per channel.
REQ-002 SHALL have parameter NCH, default 16, number of input channels (2..64).
REQ-003 SHALL have parameter SELW, default 4, select/channel-tag width; SHALL satisfy 2**SELW >= NCH.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port din  input  NCH*WIDTH  flat channel bus; channel k = din[k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SELW  channel select, direct mode.
REQ-008 SHALL have port mode  input  1  0 = direct, 1 = scan; sampled only in IDLE.
REQ-009 SHALL have port start  input  1  single-cycle scan request.
REQ-010 SHALL have port en_mask  input  NCH  channels included in a scan; sampled on accepted start.
REQ-011 SHALL have port q_ready  input  1  downstream accepts q this cycle.
REQ-012 SHALL have port q  output  WIDTH  registered selected data.
REQ-013 SHALL have port q_ch  output  SELW  channel index of q.
REQ-014 SHALL have port q_valid  output  1  q/q_ch valid.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at scan completion.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, DRAIN.
REQ-018 In IDLE with mode=0 and sel<NCH: next cycle q=din[sel], q_ch=sel, q_valid=1 (latency 1, q_ready ignored).
REQ-019 In IDLE with mode=0 and sel>=NCH: q, q_ch hold; q_valid=0 next cycle.
REQ-020 In IDLE with mode=1 and start=0: q, q_ch hold; q_valid cleared once q_ready=1.
REQ-021 In IDLE with mode=1 and start=1: latch en_mask into mask_r, set pointer to lowest set bit, go SCAN; if en_mask=0, stay IDLE and pulse done next cycle, no q_valid.
REQ-022 In SCAN, output slot free when q_valid=0 or q_ready=1; when free, capture q=din[ptr], q_ch=ptr, q_valid=1.
REQ-023 When not free, q, q_ch, q_valid SHALL hold unchanged (stable under back-pressure).
REQ-024 After a capture, ptr SHALL advance to the next higher set bit of mask_r; capture of the highest set bit SHALL transition to DRAIN.
REQ-025 Disabled channels SHALL be skipped with zero cycle cost (one capture per cycle when q_ready held high).
REQ-026 In DRAIN, when q_ready=1 with q_valid=1: clear q_valid, pulse done, go IDLE.
REQ-027 start while busy=1 SHALL be ignored; mode, en_mask, sel changes while busy SHALL not affect the scan.
REQ-028 din SHALL be sampled on the capture edge (live data, not a start-time snapshot).
REQ-029 Pointer SHALL never address a channel >= NCH; no wrap-around within one scan.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, q=0, q_ch=0, q_valid=0, busy=0, done=0, mask_r=0, ptr=0.
REQ-031 rst mid-scan SHALL abort the scan without done pulse; rst SHALL override start in the same cycle.

Verification
REQ-032 Direct: mode=0, sel=5, din[5]=0xA5A5_0005 -> next cycle q=0xA5A5_0005, q_ch=5, q_valid=1; sel=15 tracks in 1 cycle.
REQ-033 Full scan: mode=1, en_mask=0xFFFF, start, q_ready=1 -> q_ch 0..15 on 16 consecutive cycles, done one cycle after channel 15 accepted, busy low after.
REQ-034 Sparse scan with back-pressure: en_mask=0x8421, q_ready toggling 1/0 -> only channels 0,5,10,15 emitted, q stable on q_ready=0 cycles, exactly one done.
REQ-035 Empty mask: start with en_mask=0 -> done pulse next cycle, q_valid never asserted, busy stays 0.
REQ-036 Reset mid-scan: rst after 3 captures -> all outputs 0 next cycle, no done; new start runs a clean scan from lowest enabled channel.
REQ-037 Ignored start: second start and en_mask change during a scan -> original scan completes unchanged, single done.
